ccx_ic_xbar: RTL and testbench

Parametrised core-complex crossbar: routes NR requester memory ports (CPU instruction/data, debug, DMA) to NT target ports (ROM, RAM, EXT, peripherals) through a per-target address-region table. Each target has a round-robin arbiter. Each target keeps an in-order ID FIFO to steer responses back. Unmapped addresses receive a local error response. Instantiated at the core-complex top, between the requester buses and the memory/peripheral buses.

---
 rtl/ccx_ic_pkg.sv | 27 ++
 rtl/ccx_ic_rr_arbiter.sv | 47 ++++
 rtl/ccx_ic_xbar.sv | 186 ++++++++++++++++++
 tb/tb_ccx_ic_xbar.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccx_ic_pkg.sv
// Shared types, default sizes, a default region map and the address-region check
// for the core-complex crossbar.
package ccx_ic_pkg;

    localparam int CCX_NR = 2;
    localparam int CCX_NT = 3;
    localparam int CCX_AW = 39;
    localparam int CCX_DW = 64;

    typedef logic [$clog2(CCX_NR)-1:0] req_idx_t;
    typedef logic [$clog2(CCX_NT)-1:0] tgt_idx_t;

    // ROM at 0x0, RAM at 0x8000_0000, EXT at 0x9000_0000, each a 256 MiB window.
    localparam logic [CCX_NT-1:0][CCX_AW-1:0] CCX_DEF_BASE = {
        39'h00_9000_0000, 39'h00_8000_0000, 39'h00_0000_0000
    };
    localparam logic [CCX_NT-1:0][CCX_AW-1:0] CCX_DEF_MASK = {
        39'h7F_F000_0000, 39'h7F_F000_0000, 39'h7F_F000_0000
    };

    function automatic logic region_hit(input logic [CCX_AW-1:0] addr,
                                        input logic [CCX_AW-1:0] base,
                                        input logic [CCX_AW-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/ccx_ic_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// one past the winner whenever the grant is taken.
module ccx_ic_rr_arbiter #(
    parameter  int NR = 2,
    localparam int IW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic [NR-1:0] req,
    input  logic          adv,
    output logic [NR-1:0] gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int            sel;

    // NOTE: combinational blocks use blocking '=' so the found flag carries across
    // loop iterations; flops below use non-blocking '<='.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sel     = 0;
        for (int k = 0; k < NR; k++) begin
            sel = (int'(ptr_q) + k) % NR;
            if (!found && req[sel]) begin
                found        = 1'b1;
                gnt[sel]     = 1'b1;
                gnt_idx      = IW'(sel);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv && found) begin
            ptr_d = (int'(gnt_idx) == NR - 1) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ccx_ic_xbar.sv
// Core-complex crossbar: NR requesters to NT region-decoded targets with per-target
// round-robin arbitration, in-order ID FIFOs for response steering and local error replies.
module ccx_ic_xbar
    import ccx_ic_pkg::*;
#(
    parameter int NR = CCX_NR,
    parameter int NT = CCX_NT,
    parameter int AW = CCX_AW,
    parameter int DW = CCX_DW,
    parameter int OS = 2,
    parameter int FD = 4,
    parameter logic [NT-1:0][AW-1:0] TGT_BASE = '0,
    parameter logic [NT-1:0][AW-1:0] TGT_MASK = '0
) (
    input  logic                     g_clk,
    input  logic                     g_reset,
    input  logic [NR-1:0]            r_req,
    output logic [NR-1:0]            r_gnt,
    input  logic [NR-1:0][AW-1:0]    r_addr,
    input  logic [NR-1:0]            r_wen,
    input  logic [NR-1:0][DW/8-1:0]  r_strb,
    input  logic [NR-1:0][DW-1:0]    r_wdata,
    output logic [NR-1:0]            r_rsp_valid,
    input  logic [NR-1:0]            r_rsp_ready,
    output logic [NR-1:0]            r_rsp_err,
    output logic [NR-1:0][DW-1:0]    r_rdata,
    output logic [NT-1:0]            t_req,
    input  logic [NT-1:0]            t_gnt,
    output logic [NT-1:0][AW-1:0]    t_addr,
    output logic [NT-1:0]            t_wen,
    output logic [NT-1:0][DW/8-1:0]  t_strb,
    output logic [NT-1:0][DW-1:0]    t_wdata,
    input  logic [NT-1:0]            t_rsp_valid,
    output logic [NT-1:0]            t_rsp_ready,
    input  logic [NT-1:0]            t_rsp_err,
    input  logic [NT-1:0][DW-1:0]    t_rdata
);
    localparam int RIW = (NR > 1) ? $clog2(NR) : 1;
    localparam int TIW = (NT > 1) ? $clog2(NT) : 1;
    localparam int OCW = $clog2(OS + 1);
    localparam int FPW = $clog2(FD);
    localparam int CW  = FPW + 1;

    typedef logic [RIW-1:0] rid_t;
    typedef logic [TIW-1:0] tid_t;
    typedef logic [OCW-1:0] ocnt_t;

    tid_t           dec_tgt [NR];
    logic [NR-1:0]  dec_hit, elig, unmap_gnt, acc, rsp_xfer;
    logic [NR-1:0]  cand    [NT];
    logic [NR-1:0]  arb_gnt [NT];
    rid_t           arb_idx [NT];
    rid_t           head;
    logic [NT-1:0]  fifo_full, fifo_empty, push, pop;

    ocnt_t          os_cnt_q  [NR], os_cnt_d  [NR];
    tid_t           cur_tgt_q [NR], cur_tgt_d [NR];
    logic [NR-1:0]  err_pend_q, err_pend_d;
    rid_t           fifo_mem_q [NT][FD], fifo_mem_d [NT][FD];
    logic [FPW-1:0] wptr_q [NT], wptr_d [NT], rptr_q [NT], rptr_d [NT];
    logic [CW-1:0]  cnt_q  [NT], cnt_d  [NT];
    logic           proto_err_q, proto_err_d;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            dec_hit[i] = 1'b0;
            dec_tgt[i] = '0;
            for (int t = NT - 1; t >= 0; t--) begin
                if (region_hit(r_addr[i], TGT_BASE[t], TGT_MASK[t])) begin
                    dec_hit[i] = 1'b1;
                    dec_tgt[i] = tid_t'(t);
                end
            end
            elig[i] = r_req[i] && dec_hit[i] && !err_pend_q[i] && (int'(os_cnt_q[i]) < OS)
                      && (os_cnt_q[i] == '0 || dec_tgt[i] == cur_tgt_q[i]);
            unmap_gnt[i] = r_req[i] && !dec_hit[i] && !err_pend_q[i] && (os_cnt_q[i] == '0);
        end
        for (int t = 0; t < NT; t++) begin
            for (int i = 0; i < NR; i++) begin
                cand[t][i] = elig[i] && (dec_tgt[i] == tid_t'(t));
            end
        end
    end

    for (genvar t = 0; t < NT; t++) begin : g_arb
        ccx_ic_rr_arbiter #(.NR(NR)) u_arb (
            .g_clk   (g_clk),
            .g_reset (g_reset),
            .req     (cand[t]),
            .adv     (push[t]),
            .gnt     (arb_gnt[t]),
            .gnt_idx (arb_idx[t])
        );
    end

    // Request path: a full ID FIFO masks t_req so a push can never overflow it.
    always_comb begin
        r_gnt = unmap_gnt;
        acc   = '0;
        for (int t = 0; t < NT; t++) begin
            fifo_full[t]  = (int'(cnt_q[t]) == FD);
            fifo_empty[t] = (cnt_q[t] == '0);
            t_req[t]      = (|cand[t]) && !fifo_full[t];
            t_addr[t]     = r_addr[arb_idx[t]];
            t_wen[t]      = r_wen[arb_idx[t]];
            t_strb[t]     = r_strb[arb_idx[t]];
            t_wdata[t]    = r_wdata[arb_idx[t]];
            push[t]       = t_req[t] && t_gnt[t];
            if (push[t]) begin
                r_gnt = r_gnt | arb_gnt[t];
                acc   = acc | arb_gnt[t];
            end
        end
    end

    always_comb begin
        r_rsp_valid = err_pend_q;
        r_rsp_err   = err_pend_q;
        r_rdata     = '0;
        rsp_xfer    = '0;
        pop         = '0;
        t_rsp_ready = '0;
        head        = '0;
        proto_err_d = proto_err_q;
        for (int t = 0; t < NT; t++) begin
            if (fifo_empty[t]) begin
                t_rsp_ready[t] = 1'b1;
                if (t_rsp_valid[t]) proto_err_d = 1'b1;
            end else begin
                head              = fifo_mem_q[t][rptr_q[t]];
                r_rsp_valid[head] = t_rsp_valid[t];
                r_rsp_err[head]   = t_rsp_err[t];
                r_rdata[head]     = t_rdata[t];
                t_rsp_ready[t]    = r_rsp_ready[head];
                pop[t]            = t_rsp_valid[t] && r_rsp_ready[head];
                rsp_xfer[head]    = rsp_xfer[head] | pop[t];
            end
        end
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        for (int i = 0; i < NR; i++) begin
            os_cnt_d[i]   = os_cnt_q[i] + ocnt_t'(acc[i]) - ocnt_t'(rsp_xfer[i]);
            cur_tgt_d[i]  = acc[i] ? dec_tgt[i] : cur_tgt_q[i];
            err_pend_d[i] = unmap_gnt[i] | (err_pend_q[i] & ~r_rsp_ready[i]);
        end
        for (int t = 0; t < NT; t++) begin
            if (push[t]) fifo_mem_d[t][wptr_q[t]] = arb_idx[t];
            wptr_d[t] = wptr_q[t] + FPW'(push[t]);
            rptr_d[t] = rptr_q[t] + FPW'(pop[t]);
            cnt_d[t]  = cnt_q[t] + CW'(push[t]) - CW'(pop[t]);
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            for (int i = 0; i < NR; i++) begin
                os_cnt_q[i]  <= '0;
                cur_tgt_q[i] <= '0;
            end
            for (int t = 0; t < NT; t++) begin
                wptr_q[t] <= '0;
                rptr_q[t] <= '0;
                cnt_q[t]  <= '0;
            end
            err_pend_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            os_cnt_q    <= os_cnt_d;
            cur_tgt_q   <= cur_tgt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            err_pend_q  <= err_pend_d;
            proto_err_q <= proto_err_d;
        end
    end

    // NOTE: ID storage has no reset; an entry is only read after the count says it was written.
    always_ff @(posedge g_clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

endmodule

// File: tb/tb_ccx_ic_xbar.sv
// Directed bench for ccx_ic_xbar: a table of idle-state routing vectors followed by
// hand-written multi-cycle sequences for arbitration, limits, errors and reset.
module tb_ccx_ic_xbar;
    import ccx_ic_pkg::*;

    localparam int NR = CCX_NR;
    localparam int NT = CCX_NT;
    localparam int AW = CCX_AW;
    localparam int DW = CCX_DW;

    localparam logic [AW-1:0] A0 = 39'h00_0000_1000;
    localparam logic [AW-1:0] A1 = 39'h00_8000_0020;
    localparam logic [AW-1:0] A2 = 39'h00_9000_0040;
    localparam logic [AW-1:0] AU = 39'h00_F000_0000;
    localparam logic [DW-1:0] RD1 = 64'h1111_2222_3333_4444;

    logic                    g_clk = 1'b0;
    logic                    g_reset;
    logic [NR-1:0]           r_req, r_gnt, r_wen, r_rsp_valid, r_rsp_ready, r_rsp_err;
    logic [NR-1:0][AW-1:0]   r_addr;
    logic [NR-1:0][DW/8-1:0] r_strb;
    logic [NR-1:0][DW-1:0]   r_wdata, r_rdata;
    logic [NT-1:0]           t_req, t_gnt, t_wen, t_rsp_valid, t_rsp_ready, t_rsp_err;
    logic [NT-1:0][AW-1:0]   t_addr;
    logic [NT-1:0][DW/8-1:0] t_strb;
    logic [NT-1:0][DW-1:0]   t_wdata, t_rdata;

    ccx_ic_xbar #(
        .NR(NR), .NT(NT), .AW(AW), .DW(DW), .OS(2), .FD(4),
        .TGT_BASE(CCX_DEF_BASE), .TGT_MASK(CCX_DEF_MASK)
    ) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .r_req(r_req), .r_gnt(r_gnt), .r_addr(r_addr), .r_wen(r_wen),
        .r_strb(r_strb), .r_wdata(r_wdata),
        .r_rsp_valid(r_rsp_valid), .r_rsp_ready(r_rsp_ready),
        .r_rsp_err(r_rsp_err), .r_rdata(r_rdata),
        .t_req(t_req), .t_gnt(t_gnt), .t_addr(t_addr), .t_wen(t_wen),
        .t_strb(t_strb), .t_wdata(t_wdata),
        .t_rsp_valid(t_rsp_valid), .t_rsp_ready(t_rsp_ready),
        .t_rsp_err(t_rsp_err), .t_rdata(t_rdata)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [1:0]    req;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [2:0]    exp_treq;
        logic [2:0]    exp_win;
    } vec_t;

    vec_t vecs [7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge g_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [2:0] tg, input logic [2:0] trv, input logic [1:0] rdy);
        r_req       = req;
        r_addr[0]   = a0;
        r_addr[1]   = a1;
        t_gnt       = tg;
        t_rsp_valid = trv;
        r_rsp_ready = rdy;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        req_idx_t w;

        vecs[0] = '{2'b00, A0, A0, 3'b000, 3'b000};
        vecs[1] = '{2'b01, A0, A0, 3'b001, 3'b000};
        vecs[2] = '{2'b10, A0, A2, 3'b100, 3'b100};
        vecs[3] = '{2'b11, A1, A1, 3'b010, 3'b000};
        vecs[4] = '{2'b11, A0, A2, 3'b101, 3'b100};
        vecs[5] = '{2'b11, A2, A0, 3'b101, 3'b001};
        vecs[6] = '{2'b10, A0, A1, 3'b010, 3'b010};

        g_reset    = 1'b1;
        r_wen      = 2'b10;
        r_strb[0]  = 8'hFF;
        r_strb[1]  = 8'h0F;
        r_wdata[0] = 64'hAAAA_0000_0000_00A0;
        r_wdata[1] = 64'hBBBB_0000_0000_00B1;
        t_rsp_err  = 3'b000;
        t_rdata    = '0;
        t_rdata[1] = RD1;
        t_rdata[2] = 64'h5555_6666_7777_8888;
        drive(2'b00, A0, A0, 3'b000, 3'b000, 2'b00);

        check("reset r_gnt", r_gnt, 0);
        check("reset t_req", t_req, 0);
        check("reset r_rsp_valid", r_rsp_valid, 0);
        check("reset r_rsp_err", r_rsp_err, 0);
        check("reset t_rsp_ready", t_rsp_ready, 3'b111);
        tick();
        tick();
        g_reset = 1'b0;

        // Idle-state routing table: no target grants, so state does not move.
        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].req, vecs[v].a0, vecs[v].a1, 3'b000, 3'b000, 2'b00);
            check($sformatf("vec%0d t_req", v), t_req, vecs[v].exp_treq);
            check($sformatf("vec%0d r_gnt", v), r_gnt, 0);
            for (int t = 0; t < NT; t++) begin
                if (vecs[v].exp_treq[t]) begin
                    w = req_idx_t'(vecs[v].exp_win[t]);
                    check($sformatf("vec%0d t%0d addr", v, t), t_addr[t], r_addr[w]);
                    check($sformatf("vec%0d t%0d wdata", v, t), t_wdata[t], r_wdata[w]);
                    check($sformatf("vec%0d t%0d wen", v, t), t_wen[t], r_wen[w]);
                end
            end
            tick();
        end

        // Round robin on target 1 with a response one cycle behind each accept.
        drive(2'b11, A1, A1, 3'b010, 3'b000, 2'b11);
        check("rr c0 r_gnt", r_gnt, 2'b01);
        tick();
        drive(2'b11, A1, A1, 3'b010, 3'b010, 2'b11);
        check("rr c1 r_gnt", r_gnt, 2'b10);
        check("rr c1 rsp_valid", r_rsp_valid, 2'b01);
        check("rr c1 rdata0", r_rdata[0], RD1);
        tick();
        drive(2'b11, A1, A1, 3'b010, 3'b010, 2'b11);
        check("rr c2 r_gnt", r_gnt, 2'b01);
        check("rr c2 rsp_valid", r_rsp_valid, 2'b10);
        tick();
        drive(2'b11, A1, A1, 3'b010, 3'b010, 2'b11);
        check("rr c3 r_gnt", r_gnt, 2'b10);
        check("rr c3 rsp_valid", r_rsp_valid, 2'b01);
        tick();
        drive(2'b00, A1, A1, 3'b000, 3'b010, 2'b11);
        check("rr c4 rsp_valid", r_rsp_valid, 2'b10);
        tick();

        // Outstanding limit: requester 0 to target 2, OS=2.
        drive(2'b01, A2, A0, 3'b100, 3'b000, 2'b01);
        check("os c0 r_gnt", r_gnt, 2'b01);
        tick();
        drive(2'b01, A2, A0, 3'b100, 3'b000, 2'b01);
        check("os c1 r_gnt", r_gnt, 2'b01);
        tick();
        drive(2'b01, A2, A0, 3'b100, 3'b000, 2'b01);
        check("os c2 r_gnt", r_gnt, 2'b00);
        check("os c2 t_req", t_req, 3'b000);
        tick();
        drive(2'b01, A2, A0, 3'b100, 3'b100, 2'b01);
        check("os c3 r_gnt", r_gnt, 2'b00);
        check("os c3 rsp_valid", r_rsp_valid, 2'b01);
        tick();
        drive(2'b01, A2, A0, 3'b100, 3'b100, 2'b01);
        check("os c4 r_gnt", r_gnt, 2'b01);
        tick();
        drive(2'b00, A2, A0, 3'b000, 3'b100, 2'b01);
        check("os c5 rsp_valid", r_rsp_valid, 2'b01);
        tick();

        // No cross-target reordering: requester 1 to target 0, then target 2.
        drive(2'b10, A0, A0, 3'b001, 3'b000, 2'b10);
        check("xt c0 r_gnt", r_gnt, 2'b10);
        tick();
        drive(2'b10, A0, A2, 3'b101, 3'b000, 2'b10);
        check("xt c1 r_gnt", r_gnt, 2'b00);
        check("xt c1 t_req", t_req, 3'b000);
        tick();
        drive(2'b10, A0, A2, 3'b101, 3'b001, 2'b10);
        check("xt c2 r_gnt", r_gnt, 2'b00);
        check("xt c2 rsp_valid", r_rsp_valid, 2'b10);
        tick();
        drive(2'b10, A0, A2, 3'b101, 3'b000, 2'b10);
        check("xt c3 r_gnt", r_gnt, 2'b10);
        check("xt c3 t_req", t_req, 3'b100);
        tick();
        drive(2'b00, A0, A2, 3'b000, 3'b100, 2'b10);
        check("xt c4 rsp_valid", r_rsp_valid, 2'b10);
        tick();

        // Unmapped address: immediate grant, local error reply one cycle later.
        drive(2'b01, AU, A0, 3'b111, 3'b000, 2'b00);
        check("um c0 r_gnt", r_gnt, 2'b01);
        check("um c0 t_req", t_req, 3'b000);
        check("um c0 rsp_valid", r_rsp_valid, 2'b00);
        tick();
        drive(2'b01, AU, A0, 3'b111, 3'b000, 2'b00);
        check("um c1 rsp_valid", r_rsp_valid, 2'b01);
        check("um c1 rsp_err", r_rsp_err, 2'b01);
        check("um c1 rdata0", r_rdata[0], 64'h0);
        check("um c1 r_gnt held", r_gnt, 2'b00);
        tick();
        drive(2'b00, AU, A0, 3'b000, 3'b000, 2'b01);
        check("um c2 rsp_valid", r_rsp_valid, 2'b01);
        tick();
        drive(2'b00, AU, A0, 3'b000, 3'b000, 2'b00);
        check("um c3 rsp_valid", r_rsp_valid, 2'b00);
        tick();

        // ID FIFO full on target 1: four accepts, no responses.
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, A1, A1, 3'b010, 3'b000, 2'b11);
            check($sformatf("ff c%0d r_gnt", c), r_gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        drive(2'b11, A1, A1, 3'b010, 3'b000, 2'b11);
        check("ff c4 t_req", t_req[1], 1'b0);
        check("ff c4 r_gnt", r_gnt, 2'b00);
        tick();
        drive(2'b11, A1, A1, 3'b010, 3'b010, 2'b11);
        check("ff c5 t_req", t_req[1], 1'b0);
        check("ff c5 rsp_valid", r_rsp_valid, 2'b01);
        tick();
        drive(2'b11, A1, A1, 3'b010, 3'b000, 2'b11);
        check("ff c6 t_req", t_req[1], 1'b1);
        check("ff c6 r_gnt", r_gnt, 2'b01);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(2'b00, A1, A1, 3'b000, 3'b010, 2'b11);
            check($sformatf("ff drain%0d rsp_valid", c), r_rsp_valid, (c % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        drive(2'b00, A0, A0, 3'b000, 3'b000, 2'b00);
        check("proto flag clear", dut.proto_err_q, 1'b0);
        tick();

        // Reset with two outstanding, then a late response must be discarded.
        drive(2'b01, A2, A0, 3'b100, 3'b000, 2'b00);
        check("rst c0 r_gnt", r_gnt, 2'b01);
        tick();
        drive(2'b01, A2, A0, 3'b100, 3'b000, 2'b00);
        check("rst c1 r_gnt", r_gnt, 2'b01);
        tick();
        g_reset = 1'b1;
        drive(2'b00, A2, A0, 3'b000, 3'b000, 2'b00);
        check("rst mid t_req", t_req, 3'b000);
        check("rst mid t_rsp_ready", t_rsp_ready, 3'b111);
        tick();
        g_reset = 1'b0;
        tick();
        drive(2'b00, A2, A0, 3'b000, 3'b100, 2'b11);
        check("late rsp r_rsp_valid", r_rsp_valid, 2'b00);
        check("late rsp t_rsp_ready", t_rsp_ready[2], 1'b1);
        tick();
        drive(2'b00, A2, A0, 3'b000, 3'b000, 2'b00);
        check("proto flag sticky", dut.proto_err_q, 1'b1);
        check("after late r_rsp_valid", r_rsp_valid, 2'b00);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
